// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR multiply-accumulate sequencer: state encoding
// and the default geometry/latency constants.
package fir_seq_pkg;

  localparam int TAPS_DEF         = 256;
  localparam int MEM_LATENCY_DEF  = 1;
  localparam int MULT_LATENCY_DEF = 3;
  localparam int OUT_MSB_DEF      = 54;
  localparam int DATA_W           = 24;
  localparam int ACC_W            = 56;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR output per input sample: writes the sample into the ring
// buffer, walks TAPS sample/coefficient address pairs, drains the MAC and captures.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS         = TAPS_DEF,
  parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int OUT_MSB      = OUT_MSB_DEF,
  localparam int AW          = $clog2(TAPS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_strobe,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     smp_wr_en,
  output logic [AW-1:0]            smp_wr_addr,
  output logic signed [DATA_W-1:0] smp_wr_data,
  output logic [AW-1:0]            smp_rd_addr,
  output logic [AW-1:0]            coef_addr,
  output logic                     mac_clear,
  input  logic signed [ACC_W-1:0]  mac_acc,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_strobe,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CW        = AW + 1;
  localparam int DRAIN_LEN = MEM_LATENCY + MULT_LATENCY + 1;

  seq_state_e               state_r, state_s;
  logic [CW-1:0]            cnt_r, cnt_s;
  logic [AW-1:0]            wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]            rd_addr_r, rd_addr_s;
  logic [AW-1:0]            coef_addr_r, coef_addr_s;
  logic                     mac_clear_r, mac_clear_s;
  logic signed [DATA_W-1:0] out_data_r, out_data_s;
  logic                     out_strobe_r, out_strobe_s;
  logic                     busy_r, busy_s;
  logic                     overrun_r, overrun_s;
  logic                     accept_s;
  logic                     acc_unused_s;

  // The write port must act in the same cycle the strobe arrives.
  assign accept_s     = (state_r == IDLE) && in_strobe;
  assign smp_wr_en    = accept_s;
  assign smp_wr_addr  = wr_ptr_r;
  assign smp_wr_data  = in_data;
  assign acc_unused_s = ^mac_acc;

  assign smp_rd_addr = rd_addr_r;
  assign coef_addr   = coef_addr_r;
  assign mac_clear   = mac_clear_r;
  assign out_data    = out_data_r;
  assign out_strobe  = out_strobe_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    wr_ptr_s    = wr_ptr_r;
    rd_addr_s   = rd_addr_r;
    coef_addr_s = coef_addr_r;
    out_data_s  = out_data_r;
    overrun_s   = overrun_r | (in_strobe && (state_r != IDLE));
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s     = RUN;
          cnt_s       = {CW{1'b0}};
          wr_ptr_s    = wr_ptr_r + AW'(1);
          rd_addr_s   = wr_ptr_r;
          coef_addr_s = {AW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(TAPS - 1)) begin
          state_s = DRAIN;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s       = cnt_r + CW'(1);
          rd_addr_s   = rd_addr_r - AW'(1);
          coef_addr_s = coef_addr_r + AW'(1);
        end
      end
      DRAIN: begin
        // Addresses hold here; the last products are still in flight.
        if (cnt_r == CW'(DRAIN_LEN - 1)) begin
          state_s    = DONE;
          cnt_s      = {CW{1'b0}};
          out_data_s = mac_acc[OUT_MSB -: DATA_W];
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    mac_clear_s  = (state_s == RUN) && (cnt_s < CW'(MEM_LATENCY));
    busy_s       = (state_s != IDLE);
    out_strobe_s = (state_s == DONE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      rd_addr_r    <= {AW{1'b0}};
      coef_addr_r  <= {AW{1'b0}};
      mac_clear_r  <= 1'b1;
      out_data_r   <= {DATA_W{1'b0}};
      out_strobe_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_addr_r    <= rd_addr_s;
      coef_addr_r  <= coef_addr_s;
      mac_clear_r  <= mac_clear_s;
      out_data_r   <= out_data_s;
      out_strobe_r <= out_strobe_s;
      busy_r       <= busy_s;
      overrun_r    <= overrun_s;
    end
  end

endmodule
